// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Sequencing controller for a 32-bit multicycle MIPS datapath. It decodes the
// current instruction word, drives every datapath mux select, and sequences
// fetch, execute and data-memory phases. Exactly one instruction retires per
// pc_we pulse. SYSCALL or a data-memory timeout stops the controller until
// reset.
//
// Configuration macro:
//   MIPS_CTRL_PERF_EN  adds the saturating cycle_cnt / retire_cnt outputs.
//
// Parameters:
//   XLEN        datapath width (instruction word, performance counters)
//   MEM_TO_MAX  data-memory wait cycles allowed before halting; 0 = wait forever
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   inst, inst_valid           instruction word (stable until pc_we) and valid
//   zero, negative             ALU flags used by conditional branches
//   mem_ready                  data memory finished the current access
//   reg_dest, alu_src,
//   mem_or_reg, pc_or_mem      datapath mux selects (decoded from inst)
//   does_shift_amount_need,
//   is_unsigned, alu_operation ALU operand selects and operation code
//   branch, jump, jump_register PC source strobes (execute cycle only)
//   reg_write_enable, pc_we    register-file write strobe, retire strobe
//   mem_req, mem_we            data-memory request and write qualifier
//   halted                     sticky stop indicator
//   cycle_cnt, retire_cnt      performance counters (MIPS_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int XLEN       = 32,
  parameter int MEM_TO_MAX = 255
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] inst,
  input  logic            inst_valid,
  input  logic            zero,
  input  logic            negative,
  input  logic            mem_ready,
  output logic            reg_dest,
  output logic            alu_src,
  output logic            mem_or_reg,
  output logic            pc_or_mem,
  output logic            branch,
  output logic            jump,
  output logic            jump_register,
  output logic            does_shift_amount_need,
  output logic            is_unsigned,
  output logic [3:0]      alu_operation,
  output logic            reg_write_enable,
  output logic            pc_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic            halted
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] retire_cnt
`endif
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Branch condition kinds
  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_NE = 2'd1;
  localparam logic [1:0] BR_LE = 2'd2;
  localparam logic [1:0] BR_GT = 2'd3;

  // Memory wait counter counts 0 .. MEM_TO_MAX-1; the last value triggers timeout.
  localparam int              TO_W    = (MEM_TO_MAX > 1) ? $clog2(MEM_TO_MAX) : 1;
  localparam bit              TO_EN   = (MEM_TO_MAX > 0);
  localparam logic [TO_W-1:0] TO_LAST = (MEM_TO_MAX > 0) ? TO_W'(MEM_TO_MAX - 1) : '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_inst_s;

  logic       dec_reg_dest_s;
  logic       dec_alu_src_s;
  logic       dec_mem_or_reg_s;
  logic       dec_pc_or_mem_s;
  logic       dec_shamt_s;
  logic       dec_unsigned_s;
  logic [3:0] dec_alu_op_s;
  logic       dec_writes_s;
  logic       dec_is_lw_s;
  logic       dec_is_sw_s;
  logic       dec_branch_s;
  logic [1:0] dec_br_kind_s;
  logic       dec_jump_s;
  logic       dec_jr_s;
  logic       dec_syscall_s;
  logic       br_taken_s;
  logic       mem_retire_s;

  state_t          state_r;
  logic            pc_we_r;
  logic            rwe_r;
  logic            branch_r;
  logic            jump_r;
  logic            jr_r;
  logic            mem_req_r;
  logic            mem_we_r;
  logic            halted_r;
  logic            halt_pend_r;
  logic [TO_W-1:0] wait_cnt_r;

  assign opcode_s      = inst[31:26];
  assign funct_s       = inst[5:0];
  // Register fields, shamt and immediates are consumed by the datapath only.
  assign unused_inst_s = ^inst[25:6];

  // Instruction decode: mux selects, ALU operation and instruction class.
  always_comb begin
    dec_reg_dest_s   = 1'b0;
    dec_alu_src_s    = 1'b0;
    dec_mem_or_reg_s = 1'b0;
    dec_pc_or_mem_s  = 1'b0;
    dec_shamt_s      = 1'b0;
    dec_unsigned_s   = 1'b0;
    dec_alu_op_s     = ALU_ADD;
    dec_writes_s     = 1'b0;
    dec_is_lw_s      = 1'b0;
    dec_is_sw_s      = 1'b0;
    dec_branch_s     = 1'b0;
    dec_br_kind_s    = BR_EQ;
    dec_jump_s       = 1'b0;
    dec_jr_s         = 1'b0;
    dec_syscall_s    = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_ADDU: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_ADD;
          end
          FN_SUB, FN_SUBU: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SUB;
          end
          FN_AND: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_AND;
          end
          FN_OR: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_OR;
          end
          FN_XOR: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_XOR;
          end
          FN_NOR: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_NOR;
          end
          FN_SLT: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SLT;
          end
          FN_SLTU: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SLTU;
          end
          FN_SLL: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SLL;
            dec_shamt_s    = 1'b1;
          end
          FN_SRL: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SRL;
            dec_shamt_s    = 1'b1;
          end
          FN_SRA: begin
            dec_reg_dest_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SRA;
            dec_shamt_s    = 1'b1;
          end
          FN_JR:      dec_jr_s      = 1'b1;
          FN_SYSCALL: dec_syscall_s = 1'b1;
          // Unknown function: retire as a NOP.
          default:    dec_writes_s  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_alu_src_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_ADD;
      end
      OP_SLTI: begin
        dec_alu_src_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_SLT;
      end
      OP_ANDI: begin
        dec_alu_src_s  = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_AND;
        dec_unsigned_s = 1'b1;
      end
      OP_ORI: begin
        dec_alu_src_s  = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_OR;
        dec_unsigned_s = 1'b1;
      end
      OP_XORI: begin
        dec_alu_src_s  = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_XOR;
        dec_unsigned_s = 1'b1;
      end
      OP_LUI: begin
        dec_alu_src_s = 1'b1; dec_writes_s = 1'b1; dec_alu_op_s = ALU_LUI;
      end
      OP_BEQ: begin
        dec_branch_s = 1'b1; dec_br_kind_s = BR_EQ; dec_alu_op_s = ALU_SUB;
      end
      OP_BNE: begin
        dec_branch_s = 1'b1; dec_br_kind_s = BR_NE; dec_alu_op_s = ALU_SUB;
      end
      OP_BLEZ: begin
        dec_branch_s = 1'b1; dec_br_kind_s = BR_LE; dec_alu_op_s = ALU_SUB;
      end
      OP_BGTZ: begin
        dec_branch_s = 1'b1; dec_br_kind_s = BR_GT; dec_alu_op_s = ALU_SUB;
      end
      OP_LW: begin
        dec_alu_src_s = 1'b1; dec_is_lw_s = 1'b1; dec_mem_or_reg_s = 1'b1;
      end
      OP_SW: begin
        dec_alu_src_s = 1'b1; dec_is_sw_s = 1'b1;
      end
      OP_J:    dec_jump_s = 1'b1;
      OP_JAL: begin
        // Link value (PC) is routed to the write port; destination is $31.
        dec_jump_s = 1'b1; dec_pc_or_mem_s = 1'b1; dec_writes_s = 1'b1;
      end
      // Unknown opcode: retire as a NOP.
      default: dec_writes_s = 1'b0;
    endcase
  end

  // Branch condition evaluated against the ALU flags of the SUB comparison.
  always_comb begin
    br_taken_s = 1'b0;
    if (dec_branch_s) begin
      case (dec_br_kind_s)
        BR_EQ:   br_taken_s = zero;
        BR_NE:   br_taken_s = ~zero;
        BR_LE:   br_taken_s = zero | negative;
        BR_GT:   br_taken_s = ~zero & ~negative;
        default: br_taken_s = 1'b0;
      endcase
    end else begin
      br_taken_s = 1'b0;
    end
  end

  // Sequencing FSM with registered strobes for the execute cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= ST_IDLE;
      pc_we_r     <= 1'b0;
      rwe_r       <= 1'b0;
      branch_r    <= 1'b0;
      jump_r      <= 1'b0;
      jr_r        <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      halted_r    <= 1'b0;
      halt_pend_r <= 1'b0;
      wait_cnt_r  <= '0;
    end else begin
      // Execute-cycle strobes are single-cycle pulses.
      pc_we_r  <= 1'b0;
      rwe_r    <= 1'b0;
      branch_r <= 1'b0;
      jump_r   <= 1'b0;
      jr_r     <= 1'b0;
      case (state_r)
        ST_IDLE: state_r <= ST_FETCH;
        ST_FETCH: begin
          if (inst_valid) begin
            if (dec_is_lw_s || dec_is_sw_s) begin
              state_r    <= ST_MEM;
              mem_req_r  <= 1'b1;
              mem_we_r   <= dec_is_sw_s;
              wait_cnt_r <= '0;
            end else begin
              state_r     <= ST_EXEC;
              pc_we_r     <= ~dec_syscall_s;
              rwe_r       <= dec_writes_s;
              branch_r    <= br_taken_s;
              jump_r      <= dec_jump_s;
              jr_r        <= dec_jr_s;
              halt_pend_r <= dec_syscall_s;
            end
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (halt_pend_r) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_MEM: begin
          // A ready in the last allowed cycle still retires.
          if (mem_ready) begin
            state_r   <= ST_FETCH;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
          end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
            state_r   <= ST_HALT;
            halted_r  <= 1'b1;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        // Corrupted state encoding: stop rather than run on undefined control.
        default: begin
          state_r   <= ST_HALT;
          halted_r  <= 1'b1;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

  // Memory retire happens in the same cycle the memory reports ready.
  assign mem_retire_s = (state_r == ST_MEM) & mem_ready;

  assign reg_dest               = dec_reg_dest_s;
  assign alu_src                = dec_alu_src_s;
  assign mem_or_reg             = dec_mem_or_reg_s;
  assign pc_or_mem              = dec_pc_or_mem_s;
  assign does_shift_amount_need = dec_shamt_s;
  assign is_unsigned            = dec_unsigned_s;
  assign alu_operation          = dec_alu_op_s;
  assign branch                 = branch_r;
  assign jump                   = jump_r;
  assign jump_register          = jr_r;
  assign mem_req                = mem_req_r;
  assign mem_we                 = mem_we_r;
  assign halted                 = halted_r;
  assign pc_we                  = pc_we_r | mem_retire_s;
  assign reg_write_enable       = rwe_r | (mem_retire_s & ~mem_we_r);

`ifdef MIPS_CTRL_PERF_EN
  logic [XLEN-1:0] cycle_cnt_r;
  logic [XLEN-1:0] retire_cnt_r;

  // Saturating cycle and retire counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cycle_cnt_r  <= '0;
      retire_cnt_r <= '0;
    end else begin
      if ((state_r != ST_HALT) && (cycle_cnt_r != {XLEN{1'b1}})) begin
        cycle_cnt_r <= cycle_cnt_r + XLEN'(1);
      end
      if (pc_we && (retire_cnt_r != {XLEN{1'b1}})) begin
        retire_cnt_r <= retire_cnt_r + XLEN'(1);
      end
    end
  end

  assign cycle_cnt  = cycle_cnt_r;
  assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Self-checking bench for mips_multicycle_ctrl. An instruction table lists the
// architectural attributes of every decoded instruction; expected cycle-level
// behaviour is derived from that table and the branch/latency rules. Directed
// scenarios come first, followed by randomized instruction streams.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  localparam int K_ALU = 0, K_BEQ = 1, K_BNE = 2, K_BLEZ = 3, K_BGTZ = 4, K_J = 5;
  localparam int K_JAL = 6, K_JR = 7, K_SYS = 8, K_LW = 9, K_SW = 10, K_UNK = 11;
  localparam int TO_MAX = 4;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] aluop;
    bit         src;
    bit         dst;
    bit         unsg;
    bit         shamt;
    bit         wr;
    int         kind;
  } ent_t;

  ent_t tbl[$];

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [31:0] inst = 32'h0;
  logic        inst_valid = 1'b0;
  logic        zero = 1'b0;
  logic        negative = 1'b0;
  logic        mem_ready = 1'b0;
  logic        reg_dest, alu_src, mem_or_reg, pc_or_mem, branch, jump, jump_register;
  logic        does_shift_amount_need, is_unsigned, reg_write_enable, pc_we;
  logic        mem_req, mem_we, halted;
  logic [3:0]  alu_operation;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int model_retire = 0;

  logic [7:0] strb;
  logic [9:0] selv;
  assign strb = {pc_we, reg_write_enable, mem_req, mem_we, branch, jump, jump_register, halted};
  assign selv = {reg_dest, alu_src, mem_or_reg, pc_or_mem, does_shift_amount_need,
                 is_unsigned, alu_operation};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.XLEN(32), .MEM_TO_MAX(TO_MAX)) dut (
    .clk(clk), .rst_b(rst_b), .inst(inst), .inst_valid(inst_valid),
    .zero(zero), .negative(negative), .mem_ready(mem_ready),
    .reg_dest(reg_dest), .alu_src(alu_src), .mem_or_reg(mem_or_reg),
    .pc_or_mem(pc_or_mem), .branch(branch), .jump(jump),
    .jump_register(jump_register),
    .does_shift_amount_need(does_shift_amount_need), .is_unsigned(is_unsigned),
    .alu_operation(alu_operation), .reg_write_enable(reg_write_enable),
    .pc_we(pc_we), .mem_req(mem_req), .mem_we(mem_we), .halted(halted)
`ifdef MIPS_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic ent_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [3:0] aluop, input bit src, input bit dst,
                              input bit unsg, input bit shamt, input bit wr, input int kind);
    ent_t e;
    e.op = op; e.fn = fn; e.aluop = aluop; e.src = src; e.dst = dst;
    e.unsg = unsg; e.shamt = shamt; e.wr = wr; e.kind = kind;
    return e;
  endfunction

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) return i;
    return 0;
  endfunction

  function automatic bit taken(input int kind, input bit z, input bit n);
    case (kind)
      K_BEQ:   return z;
      K_BNE:   return !z;
      K_BLEZ:  return z || n;
      K_BGTZ:  return !z && !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] build(input ent_t e);
    logic [31:0] r;
    r = $urandom;
    if (e.op == 6'h00) return {6'h00, r[25:6], e.fn};
    return {e.op, r[25:0]};
  endfunction

  function automatic logic [9:0] exp_sel(input ent_t e);
    return {e.dst, e.src, e.kind == K_LW, e.kind == K_JAL, e.shamt, e.unsg, e.aluop};
  endfunction

  task automatic chk_retire();
`ifdef MIPS_CTRL_PERF_EN
    chk_eq("retire_cnt", retire_cnt, 32'(model_retire));
`endif
  endtask

  // Entry/exit point: time is 1 unit after a rising edge, DUT in FETCH on exit.
  task automatic do_reset();
    rst_b = 1'b0; inst_valid = 1'b0; mem_ready = 1'b0; model_retire = 0;
    #1;
    chk_eq("reset_async", 32'(strb), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_hold", 32'(strb), 32'h0);
    rst_b = 1'b1;
    @(negedge clk);
    chk_eq("idle", 32'(strb), 32'h0);
    @(posedge clk); #1;
  endtask

  // lat: cycle (1..) in which mem_ready rises, 0 = never; rst_at: MEM cycle to reset in, 0 = none.
  task automatic run_instr(input int idx, input logic [31:0] w, input bit z, input bit n,
                           input int ninv, input int lat, input int rst_at);
    ent_t e;
    int   ncyc;
    bit   ismem;
    e = tbl[idx];
    ismem = (e.kind == K_LW) || (e.kind == K_SW);
    ncyc = (lat == 0) ? TO_MAX : lat;
    for (int i = 0; i < ninv; i++) begin
      inst = $urandom; inst_valid = 1'b0;
      @(negedge clk);
      chk_eq("fetch_wait", 32'(strb), 32'h0);
      @(posedge clk); #1;
    end
    inst = w; inst_valid = 1'b1; zero = z; negative = n;
    @(negedge clk);
    chk_eq("decode", 32'(selv), 32'(exp_sel(e)));
    chk_eq("fetch", 32'(strb), 32'h0);
    @(posedge clk); #1;
    if (ismem) begin
      for (int c = 1; c <= ncyc; c++) begin
        if (rst_at == c) begin
          rst_b = 1'b0; mem_ready = 1'b0;
          #1;
          chk_eq("mem_rst_async", 32'(strb), 32'h0);
          inst_valid = 1'b0; model_retire = 0;
          repeat (2) @(posedge clk);
          #1; rst_b = 1'b1;
          @(negedge clk);
          chk_eq("idle_after_mem_rst", 32'(strb), 32'h0);
          @(posedge clk); #1;
          return;
        end
        mem_ready = (c == lat);
        @(negedge clk);
        chk_eq(e.kind == K_LW ? "lw_mem" : "sw_mem", 32'(strb),
               32'({c == lat, (c == lat) && e.kind == K_LW, 1'b1, e.kind == K_SW, 4'b0000}));
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      if (lat == 0) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk_eq("timeout_halt", 32'(strb), 32'h01);
          @(posedge clk); #1;
        end
        do_reset();
      end else begin
        model_retire++;
        chk_retire();
      end
    end else begin
      @(negedge clk);
      chk_eq("exec", 32'(strb),
             32'({e.kind != K_SYS, e.wr, 2'b00, taken(e.kind, z, n),
                  (e.kind == K_J) || (e.kind == K_JAL), e.kind == K_JR, 1'b0}));
      @(posedge clk); #1;
      if (e.kind == K_SYS) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk_eq("syscall_halt", 32'(strb), 32'h01);
          @(posedge clk); #1;
        end
        do_reset();
      end else begin
        model_retire++;
        chk_retire();
      end
    end
  endtask

  initial begin
    int idx, lat, rst_at;
    // op, fn, aluop, src, dst, unsg, shamt, wr, kind
    tbl.push_back(mk(6'h00, 6'h20, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h21, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h22, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h23, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h24, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h25, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h26, 4'd4,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h27, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h2A, 4'd6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h2B, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h00, 4'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h02, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h03, 4'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, K_ALU));
    tbl.push_back(mk(6'h00, 6'h08, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_JR));
    tbl.push_back(mk(6'h00, 6'h0C, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_SYS));
    tbl.push_back(mk(6'h00, 6'h01, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_UNK));
    tbl.push_back(mk(6'h00, 6'h18, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_UNK));
    tbl.push_back(mk(6'h08, 6'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h09, 6'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h0C, 6'h00, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h0D, 6'h00, 4'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h0E, 6'h00, 4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h0A, 6'h00, 4'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h0F, 6'h00, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_ALU));
    tbl.push_back(mk(6'h04, 6'h00, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_BEQ));
    tbl.push_back(mk(6'h05, 6'h00, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_BNE));
    tbl.push_back(mk(6'h06, 6'h00, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_BLEZ));
    tbl.push_back(mk(6'h07, 6'h00, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_BGTZ));
    tbl.push_back(mk(6'h23, 6'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, K_LW));
    tbl.push_back(mk(6'h2B, 6'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, K_SW));
    tbl.push_back(mk(6'h02, 6'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_J));
    tbl.push_back(mk(6'h03, 6'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, K_JAL));
    tbl.push_back(mk(6'h0B, 6'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_UNK));
    tbl.push_back(mk(6'h20, 6'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, K_UNK));

    #2;
    // Reset, then IDLE -> FETCH.
    do_reset();
    // addi $1,$0,5
    run_instr(find(6'h08, 6'h00), 32'h20010005, 1'b0, 1'b0, 0, 0, 0);
    // lw $2,0($1) with ready in the third memory cycle
    run_instr(find(6'h23, 6'h00), 32'h8C220000, 1'b0, 1'b0, 0, 3, 0);
    // beq taken / not taken
    run_instr(find(6'h04, 6'h00), 32'h10220003, 1'b1, 1'b0, 0, 0, 0);
    run_instr(find(6'h04, 6'h00), 32'h10220003, 1'b0, 1'b0, 0, 0, 0);
    // inst_valid low for a while in FETCH; lw ready on first memory cycle
    run_instr(find(6'h23, 6'h00), 32'h8C220004, 1'b0, 1'b0, 3, 1, 0);
    // jal, then syscall halts (includes reset afterwards)
    run_instr(find(6'h03, 6'h00), 32'h0C000010, 1'b0, 1'b0, 0, 0, 0);
    run_instr(find(6'h00, 6'h0C), 32'h0000000C, 1'b0, 1'b0, 0, 0, 0);
    // sw never acknowledged: reset mid-access, then timeout halt
    run_instr(find(6'h2B, 6'h00), 32'hAC220000, 1'b0, 1'b0, 0, 0, 2);
    run_instr(find(6'h2B, 6'h00), 32'hAC220000, 1'b0, 1'b0, 0, 0, 0);
    // sw acknowledged in the last allowed cycle still retires
    run_instr(find(6'h2B, 6'h00), 32'hAC220008, 1'b0, 1'b0, 0, TO_MAX, 0);

    for (int it = 0; it < 250; it++) begin
      idx = $urandom_range(0, tbl.size() - 1);
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO_MAX);
      rst_at = 0;
      if ((tbl[idx].kind == K_LW || tbl[idx].kind == K_SW) && $urandom_range(0, 9) == 0)
        rst_at = $urandom_range(1, (lat == 0) ? TO_MAX : lat);
      run_instr(idx, build(tbl[idx]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), lat, rst_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
